// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package arb_pkg;
   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_e;

   localparam int MODE_IDLE = 0;

   // Index width for a slave count; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above i_rr_ptr, with wrap.
module rr_pick import arb_pkg::*; #(
   parameter int NUM_SLV = 4,
   localparam int IW = idx_w(NUM_SLV)
) (
   input  logic [NUM_SLV-1:0] i_req,
   input  logic [IW-1:0]      i_rr_ptr,
   output logic [IW-1:0]      o_gnt_idx,
   output logic               o_any_req
);
   logic [IW-1:0] w_idx;

   always_comb begin
      o_gnt_idx = '0;
      o_any_req = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         w_idx = IW'((int'(i_rr_ptr) + k) % NUM_SLV);
         if (!o_any_req && i_req[w_idx]) begin
            o_any_req = 1'b1;
            o_gnt_idx = w_idx;
         end
      end
   end
endmodule

// File: rtl/rr_stream_arbiter.sv
// N-slave round-robin burst arbiter feeding one FIFO; registered beat outputs.
module rr_stream_arbiter import arb_pkg::*; #(
   parameter int NUM_SLV = 4,
   parameter int DW      = 32,
   parameter int PVW     = 8,
   parameter int MW      = 2,
   parameter int PKT_LEN = 16,
   localparam int IW = idx_w(NUM_SLV),
   localparam int CW = $clog2(PKT_LEN + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SLV-1:0][MW-1:0]    slv_mode,
   input  logic [NUM_SLV-1:0]            slv_data_valid,
   input  logic [NUM_SLV-1:0][DW-1:0]    slv_data,
   input  logic [NUM_SLV-1:0][PVW-1:0]   slv_proc_val,
   output logic [NUM_SLV-1:0]            slv_ready,
   input  logic                          fifo_full,
   input  logic                          mstr_cmplt,
   output logic [MW-1:0]                 slvx_mode,
   output logic                          slvx_data_valid,
   output logic [DW-1:0]                 slvx_data,
   output logic [PVW-1:0]                slvx_proc_val,
   output logic [IW-1:0]                 data_source,
   output logic                          grant_active
);
   arb_state_e      r_state;
   logic [IW-1:0]   r_gnt_idx, r_rr_ptr;
   logic [CW-1:0]   r_beat_cnt;
   logic [MW-1:0]   r_slvx_mode;
   logic            r_slvx_dv;
   logic [DW-1:0]   r_slvx_data;
   logic [PVW-1:0]  r_slvx_pv;
   logic [IW-1:0]   r_src;

   logic [NUM_SLV-1:0] w_req, w_ready;
   logic [IW-1:0]      w_pick, w_next_ptr;
   logic               w_any_req, w_acc, w_last, w_exit;

   always_comb begin
      for (int i = 0; i < NUM_SLV; i++)
         w_req[i] = (slv_mode[i] != MW'(MODE_IDLE));
   end

   rr_pick #(.NUM_SLV(NUM_SLV)) u_pick (
      .i_req     (w_req),
      .i_rr_ptr  (r_rr_ptr),
      .o_gnt_idx (w_pick),
      .o_any_req (w_any_req)
   );

   // Ready is decoded from registered grant state; back-pressure and abort gate it directly.
   always_comb begin
      w_ready = '0;
      if (r_state == XFER && !fifo_full && !mstr_cmplt)
         w_ready[r_gnt_idx] = 1'b1;
   end

   assign w_acc      = w_ready[r_gnt_idx] & slv_data_valid[r_gnt_idx];
   assign w_last     = w_acc && (r_beat_cnt == CW'(PKT_LEN - 1));
   assign w_exit     = w_last || !w_req[r_gnt_idx] || mstr_cmplt;
   assign w_next_ptr = (r_gnt_idx == IW'(NUM_SLV - 1)) ? '0 : r_gnt_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_gnt_idx   <= '0;
         r_rr_ptr    <= '0;
         r_beat_cnt  <= '0;
         r_slvx_mode <= '0;
         r_slvx_dv   <= 1'b0;
         r_slvx_data <= '0;
         r_slvx_pv   <= '0;
         r_src       <= '0;
      end else begin
         r_slvx_dv <= w_acc;
         if (w_acc) begin
            r_slvx_mode <= slv_mode[r_gnt_idx];
            r_slvx_data <= slv_data[r_gnt_idx];
            r_slvx_pv   <= slv_proc_val[r_gnt_idx];
            r_src       <= r_gnt_idx;
         end
         case (r_state)
            IDLE: begin
               if (!mstr_cmplt && w_any_req) begin
                  r_gnt_idx <= w_pick;
                  r_state   <= XFER;
               end
            end
            XFER: begin
               if (w_exit) begin
                  r_state    <= IDLE;
                  r_beat_cnt <= '0;
                  r_rr_ptr   <= w_next_ptr;
               end else if (w_acc) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign slv_ready       = w_ready;
   assign slvx_mode       = r_slvx_mode;
   assign slvx_data_valid = r_slvx_dv;
   assign slvx_data       = r_slvx_data;
   assign slvx_proc_val   = r_slvx_pv;
   assign data_source     = r_src;
   assign grant_active    = (r_state == XFER);
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: bursts, round-robin order, back-pressure, aborts, reset.
module tb_rr_stream_arbiter;
   localparam int N = 4, DW = 32, PVW = 8, MW = 2, PL = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n;
   logic [N-1:0][MW-1:0]     slv_mode;
   logic [N-1:0]             slv_data_valid;
   logic [N-1:0][DW-1:0]     slv_data;
   logic [N-1:0][PVW-1:0]    slv_proc_val;
   logic [N-1:0]             slv_ready;
   logic                     fifo_full, mstr_cmplt;
   logic [MW-1:0]            slvx_mode;
   logic                     slvx_data_valid;
   logic [DW-1:0]            slvx_data;
   logic [PVW-1:0]           slvx_proc_val;
   logic [1:0]               data_source;
   logic                     grant_active;

   rr_stream_arbiter #(.NUM_SLV(N), .DW(DW), .PVW(PVW), .MW(MW), .PKT_LEN(PL)) dut (
      .clk(clk), .rst_n(rst_n), .slv_mode(slv_mode), .slv_data_valid(slv_data_valid),
      .slv_data(slv_data), .slv_proc_val(slv_proc_val), .slv_ready(slv_ready),
      .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt), .slvx_mode(slvx_mode),
      .slvx_data_valid(slvx_data_valid), .slvx_data(slvx_data), .slvx_proc_val(slvx_proc_val),
      .data_source(data_source), .grant_active(grant_active)
   );

   int errors = 0, checks = 0;
   logic [DW-1:0] base [N];
   int            sent [N];
   logic [N-1:0]  acc;
   logic [DW-1:0] q_data [$];
   logic [1:0]    q_src [$];
   logic [PVW-1:0] q_pv [$];

   // Strobe capture, well clear of both clock edges.
   always @(posedge clk) begin
      #2;
      if (slvx_data_valid === 1'b1) begin
         q_data.push_back(slvx_data);
         q_src.push_back(data_source);
         q_pv.push_back(slvx_proc_val);
      end
   end

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         slv_data[i]     = base[i] + DW'(sent[i]);
         slv_proc_val[i] = PVW'(i * 16 + sent[i]);
      end
   endtask

   // Called at a negedge after inputs are set; advances one cycle and updates the slave models.
   task automatic tick();
      #1;
      acc = slv_ready & slv_data_valid;
      @(negedge clk);
      for (int i = 0; i < N; i++) if (acc[i]) sent[i]++;
      refresh();
   endtask

   task automatic clear_all();
      slv_mode = '0; slv_data_valid = '0; fifo_full = 1'b0; mstr_cmplt = 1'b0;
      for (int i = 0; i < N; i++) begin sent[i] = 0; base[i] = '0; end
      refresh();
   endtask

   task automatic do_reset();
      clear_all();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      q_data.delete(); q_src.delete(); q_pv.delete();
   endtask

   task automatic run_until(input int s, input int target, input int budget);
      int g = 0;
      while (sent[s] < target && g < budget) begin tick(); g++; end
      checks++;
      if (sent[s] != target) begin
         errors++;
         $display("FAIL run_until slave%0d: got %0d beats expected %0d", s, sent[s], target);
      end
   endtask

   task automatic test_reset();
      clear_all();
      rst_n = 1'b0;
      slv_mode[1] = 2'd2; slv_data_valid[1] = 1'b1; base[1] = 32'hDEAD; refresh();
      tick(); tick();
      checks++; if (slv_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", slv_ready); end
      checks++; if (slvx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", slvx_data_valid); end
      checks++; if (slvx_data !== 32'h0 || slvx_mode !== 2'b0 || slvx_proc_val !== 8'h0)
         begin errors++; $display("FAIL reset_payload: got %h/%h/%h expected 0", slvx_data, slvx_mode, slvx_proc_val); end
      checks++; if (data_source !== 2'b0 || grant_active !== 1'b0)
         begin errors++; $display("FAIL reset_src_ga: got %h/%b expected 0/0", data_source, grant_active); end
      rst_n = 1'b1;
      clear_all();
      tick();
      q_data.delete(); q_src.delete(); q_pv.delete();
   endtask

   task automatic test_single_burst();
      logic ga [1:18];
      int bad = 0;
      do_reset();
      base[2] = 32'h100; slv_mode[2] = 2'd1; slv_data_valid[2] = 1'b1; refresh();
      for (int k = 1; k <= 18; k++) begin tick(); ga[k] = grant_active; end
      slv_mode[2] = '0; slv_data_valid[2] = 1'b0;
      tick(); tick(); tick();
      checks++; if (ga[1] !== 1'b1 || ga[16] !== 1'b1) begin errors++; $display("FAIL single_ga_hi: got %b/%b expected 1/1", ga[1], ga[16]); end
      checks++; if (ga[17] !== 1'b0) begin errors++; $display("FAIL single_turnaround: got %b expected 0", ga[17]); end
      checks++; if (ga[18] !== 1'b1) begin errors++; $display("FAIL single_regrant: got %b expected 1", ga[18]); end
      checks++; if (q_data.size() != 16) begin errors++; $display("FAIL single_count: got %0d expected 16", q_data.size()); end
      for (int j = 0; j < q_data.size() && j < 16; j++)
         if (q_data[j] !== 32'h100 + 32'(j) || q_src[j] !== 2'd2) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL single_data: got %0d bad beats expected 0", bad); end
      checks++; if (q_pv.size() == 0 || q_pv[0] !== 8'h20) begin errors++; $display("FAIL single_pv: got %h expected 20", q_pv.size() ? q_pv[0] : 8'hxx); end
   endtask

   task automatic test_all_round_robin();
      int g = 0, multi = 0;
      do_reset();
      for (int i = 0; i < N; i++) begin base[i] = DW'(i) << 12; slv_mode[i] = 2'd1; end
      slv_data_valid = '1; refresh();
      while (q_src.size() < 80 && g < 200) begin
         tick(); g++;
         if ($countones(slv_ready) > 1) multi++;
      end
      checks++; if (multi != 0) begin errors++; $display("FAIL rr_onehot: got %0d multi-ready cycles expected 0", multi); end
      checks++; if (q_src.size() < 80) begin errors++; $display("FAIL rr_count: got %0d expected 80", q_src.size()); end
      for (int gi = 0; gi < 5; gi++) begin
         int bad = 0;
         int s = gi % 4;
         for (int j = 0; j < 16; j++) begin
            int n = gi * 16 + j;
            if (n >= q_src.size() || q_src[n] !== 2'(s) ||
                q_data[n] !== base[s] + DW'((gi / 4) * 16 + j)) bad++;
         end
         checks++;
         if (bad != 0) begin errors++; $display("FAIL rr_grant%0d: got %0d bad beats expected 0 for slave %0d", gi, bad, s); end
      end
   endtask

   task automatic test_fifo_full();
      int bad = 0;
      do_reset();
      base[1] = 32'h500; slv_mode[1] = 2'd1; slv_data_valid[1] = 1'b1; refresh();
      run_until(1, 5, 20);
      for (int k = 0; k < 5; k++) begin
         fifo_full = 1'b1;
         #1;
         checks++; if (slv_ready !== 4'b0 || grant_active !== 1'b1)
            begin errors++; $display("FAIL full_ready%0d: got %b/%b expected 0000/1", k, slv_ready, grant_active); end
         tick();
         checks++; if (slvx_data_valid !== 1'b0) begin errors++; $display("FAIL full_strobe%0d: got %b expected 0", k, slvx_data_valid); end
      end
      fifo_full = 1'b0;
      run_until(1, 16, 30);
      slv_mode[1] = '0; slv_data_valid[1] = 1'b0;
      checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL full_end_ga: got %b expected 0", grant_active); end
      tick(); tick();
      checks++; if (q_data.size() != 16) begin errors++; $display("FAIL full_count: got %0d expected 16", q_data.size()); end
      for (int j = 0; j < q_data.size() && j < 16; j++) if (q_data[j] !== 32'h500 + 32'(j)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL full_data: got %0d bad beats expected 0", bad); end
   endtask

   task automatic test_mode_drop();
      do_reset();
      base[3] = 32'h300; slv_mode[3] = 2'd1; slv_data_valid[3] = 1'b1; refresh();
      run_until(3, 4, 20);
      slv_mode[3] = '0; slv_data_valid[3] = 1'b0;
      tick();
      checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL drop_idle: got %b expected 0", grant_active); end
      tick(); tick();
      checks++; if (q_src.size() != 4) begin errors++; $display("FAIL drop_count: got %0d expected 4", q_src.size()); end
      slv_mode[0] = 2'd1; slv_mode[3] = 2'd1;
      tick();
      #1;
      checks++; if (slv_ready !== 4'b0001) begin errors++; $display("FAIL drop_rrptr: got %b expected 0001", slv_ready); end
   endtask

   task automatic test_mstr_cmplt();
      do_reset();
      base[0] = 32'h700; slv_mode[0] = 2'd1; slv_data_valid[0] = 1'b1; refresh();
      run_until(0, 7, 20);
      mstr_cmplt = 1'b1;
      #1;
      checks++; if (slv_ready !== 4'b0) begin errors++; $display("FAIL cmplt_ready: got %b expected 0000", slv_ready); end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL cmplt_hold%0d: got %b expected 0", k, grant_active); end
      end
      mstr_cmplt = 1'b0;
      tick();
      #1;
      checks++; if (grant_active !== 1'b1 || slv_ready !== 4'b0001)
         begin errors++; $display("FAIL cmplt_regrant: got %b/%b expected 1/0001", grant_active, slv_ready); end
      checks++; if (q_data.size() != 7) begin errors++; $display("FAIL cmplt_count: got %0d expected 7", q_data.size()); end
   endtask

   task automatic test_cmplt_last_beat();
      do_reset();
      base[0] = 32'h900; slv_mode[0] = 2'd1; slv_data_valid[0] = 1'b1; refresh();
      run_until(0, 15, 30);
      mstr_cmplt = 1'b1;
      tick();
      mstr_cmplt = 1'b0; slv_mode[0] = '0; slv_data_valid[0] = 1'b0;
      checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL last_cmplt_idle: got %b expected 0", grant_active); end
      tick(); tick();
      checks++; if (q_data.size() != 15) begin errors++; $display("FAIL last_cmplt_count: got %0d expected 15", q_data.size()); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      base[2] = 32'hA00; slv_mode[2] = 2'd1; slv_data_valid[2] = 1'b1; refresh();
      run_until(2, 3, 20);
      slv_mode[1] = 2'd3; slv_data_valid[1] = 1'b1;
      rst_n = 1'b0;
      tick();
      checks++; if (slv_ready !== 4'b0 || grant_active !== 1'b0 || slvx_data_valid !== 1'b0)
         begin errors++; $display("FAIL midrst_ctrl: got %b/%b/%b expected 0000/0/0", slv_ready, grant_active, slvx_data_valid); end
      checks++; if (slvx_data !== 32'h0 || slvx_mode !== 2'b0 || slvx_proc_val !== 8'h0 || data_source !== 2'b0)
         begin errors++; $display("FAIL midrst_payload: got %h/%h/%h/%h expected 0", slvx_data, slvx_mode, slvx_proc_val, data_source); end
      rst_n = 1'b1;
      tick();
      #1;
      checks++; if (slv_ready !== 4'b0010) begin errors++; $display("FAIL midrst_first_grant: got %b expected 0010", slv_ready); end
      checks++; if (q_data.size() != 3) begin errors++; $display("FAIL midrst_count: got %0d expected 3", q_data.size()); end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_all();
      @(negedge clk);
      test_reset();
      test_single_burst();
      test_all_round_robin();
      test_fifo_full();
      test_mode_drop();
      test_mstr_cmplt();
      test_cmplt_last_beat();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
